// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of a 5-stage MIPS pipeline.
//
// Takes the latched ID/EX fields and does the following:
//   * picks the destination register,
//   * forwards operands from EX/MEM or MEM/WB (only when EX_FWD_EN is
//     defined),
//   * decodes ALU control and computes ADD/SUB/AND/OR in a single cycle.
// MUL runs on a sequential shift-add multiplier. While it iterates, stall_o
// holds the front end. The results are registered into the EX/MEM fields
// that this stage owns.
//
// Build option:
//   EX_FWD_EN  defined   -> EX/MEM and MEM/WB forwarding is active
//              undefined -> operands come straight from RSdata_i/RTdata_i,
//                           and the MEMWB_* ports are ignored
//
// Parameters:
//   XLEN        datapath width
//   MUL_CYCLES  multiplier iteration count; must equal XLEN
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   RegDst_i .. RegWrite_i, ALUOp_i    ID/EX control
//   RSdata_i, RTdata_i, immediate_i    ID/EX operands, sign-extended imm
//   RSaddr_i, RTaddr_i, RDaddr_i       ID/EX register addresses
//   MEMWB_RegWrite_i/RDaddr_i/data_i   MEM/WB writeback for forwarding
//   stall_o                            hold PC, IF/ID and ID/EX this cycle
//   MemRead_o .. RegWrite_o            EX/MEM control
//   ALUresult_o, MemWdata_o, RDaddr_o  EX/MEM data and destination
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            RegDst_i,
    input  logic            ALUSrc_i,
    input  logic            MemRead_i,
    input  logic            MemWrite_i,
    input  logic            MemtoReg_i,
    input  logic            RegWrite_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [XLEN-1:0] RSdata_i,
    input  logic [XLEN-1:0] RTdata_i,
    input  logic [XLEN-1:0] immediate_i,
    input  logic [4:0]      RSaddr_i,
    input  logic [4:0]      RTaddr_i,
    input  logic [4:0]      RDaddr_i,
    input  logic            MEMWB_RegWrite_i,
    input  logic [4:0]      MEMWB_RDaddr_i,
    input  logic [XLEN-1:0] MEMWB_data_i,
    output logic            stall_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            MemtoReg_o,
    output logic            RegWrite_o,
    output logic [XLEN-1:0] ALUresult_o,
    output logic [XLEN-1:0] MemWdata_o,
    output logic [4:0]      RDaddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_MUL = 3'd4
    } alu_ctl_t;

    localparam int         CNT_W      = $clog2(MUL_CYCLES + 1);
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;

    // EX/MEM register. The control bits are packed as
    // {MemRead, MemWrite, MemtoReg, RegWrite}.
    logic [3:0]      exmem_ctrl_reg;
    logic [XLEN-1:0] exmem_alu_reg;
    logic [XLEN-1:0] exmem_wdata_reg;
    logic [4:0]      exmem_rd_reg;

    // Multiplier state.
    mul_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] mcand_reg;
    logic [XLEN-1:0] mplier_reg;
    logic [XLEN-1:0] mul_wdata_reg;
    logic [4:0]      mul_dest_reg;
    logic [3:0]      mul_ctrl_reg;

    // Combinational datapath.
    logic [4:0]      dest;
    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    alu_ctl_t        alu_ctl;
    logic            is_mul;
    logic            start_mul;
    logic            stall;

    assign dest = RegDst_i ? RDaddr_i : RTaddr_i;

    // -----------------------------------------------------------------------
    // Operand forwarding, one generate copy per operand (0 = RS, 1 = RT).
    // When both sources match, EX/MEM wins because it is the younger result.
    // Register $0 is hard-wired to zero, so it is never forwarded.
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] opnd_raw [2];
    logic [XLEN-1:0] opnd_fwd [2];

    assign opnd_raw[0] = RSdata_i;
    assign opnd_raw[1] = RTdata_i;

`ifdef EX_FWD_EN
    logic [4:0] opnd_addr [2];

    assign opnd_addr[0] = RSaddr_i;
    assign opnd_addr[1] = RTaddr_i;
`else
    // Without forwarding, these inputs have no function.
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{RSaddr_i, MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef EX_FWD_EN
            logic hit_exmem;
            logic hit_memwb;

            assign hit_exmem = exmem_ctrl_reg[0] && (exmem_rd_reg != 5'd0)
                               && (exmem_rd_reg == opnd_addr[gi]);
            assign hit_memwb = MEMWB_RegWrite_i && (MEMWB_RDaddr_i != 5'd0)
                               && (MEMWB_RDaddr_i == opnd_addr[gi]);
            assign opnd_fwd[gi] = hit_exmem ? exmem_alu_reg
                                : (hit_memwb ? MEMWB_data_i : opnd_raw[gi]);
`else
            assign opnd_fwd[gi] = opnd_raw[gi];
`endif
        end
    endgenerate

    assign fwd_rs = opnd_fwd[0];
    assign fwd_rt = opnd_fwd[1];
    assign op_b   = ALUSrc_i ? immediate_i : fwd_rt;

    // -----------------------------------------------------------------------
    // ALU control decode. Unknown funct codes fall back to ADD.
    // -----------------------------------------------------------------------
    always_comb begin
        alu_ctl = ALU_ADD;
        case (ALUOp_i)
            2'b01: alu_ctl = ALU_SUB;
            2'b10: begin
                case (immediate_i[5:0])
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_MUL: alu_ctl = ALU_MUL;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    assign is_mul = (alu_ctl == ALU_MUL);

    // The single-cycle result for MUL is never loaded because the stage
    // stalls. The product comes from the accumulator instead.
    always_comb begin
        alu_result = fwd_rs + op_b;
        case (alu_ctl)
            ALU_SUB: alu_result = fwd_rs - op_b;
            ALU_AND: alu_result = fwd_rs & op_b;
            ALU_OR:  alu_result = fwd_rs | op_b;
            default: alu_result = fwd_rs + op_b;
        endcase
    end

    // -----------------------------------------------------------------------
    // Multiplier FSM: next state and stall.
    // The start cycle in IDLE plus MUL_CYCLES cycles in BUSY give exactly
    // MUL_CYCLES+1 stalled cycles. DONE never restarts a multiply, even
    // though the MUL is still on the inputs during that cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        start_mul  = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (is_mul) begin
                    start_mul  = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_reg == CNT_W'(MUL_CYCLES - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset forces every output low, including the combinational stall.
    assign stall_o = stall & ~rst_i;

    // -----------------------------------------------------------------------
    // State, multiplier datapath and EX/MEM register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            acc_reg         <= '0;
            mcand_reg       <= '0;
            mplier_reg      <= '0;
            mul_wdata_reg   <= '0;
            mul_dest_reg    <= '0;
            mul_ctrl_reg    <= '0;
            exmem_ctrl_reg  <= '0;
            exmem_alu_reg   <= '0;
            exmem_wdata_reg <= '0;
            exmem_rd_reg    <= '0;
        end else begin
            state_reg <= state_next;

            case (state_reg)
                ST_IDLE: begin
                    if (start_mul) begin
                        mcand_reg     <= fwd_rs;
                        mplier_reg    <= op_b;
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        mul_dest_reg  <= dest;
                        mul_wdata_reg <= fwd_rt;
                        mul_ctrl_reg  <= {MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i};
                    end
                end
                ST_BUSY: begin
                    // One shift-add step: add the multiplicand when the
                    // multiplier LSB is set, then shift both. Bits shifted
                    // past XLEN are dropped, so the accumulator keeps only
                    // the low word of the product.
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                end
                default: ;
            endcase

            if (state_reg == ST_DONE) begin
                exmem_ctrl_reg  <= mul_ctrl_reg;
                exmem_alu_reg   <= acc_reg;
                exmem_wdata_reg <= mul_wdata_reg;
                exmem_rd_reg    <= mul_dest_reg;
            end else if (stall) begin
                // Insert a bubble. Data fields keep their previous values.
                exmem_ctrl_reg <= 4'b0000;
            end else begin
                exmem_ctrl_reg  <= {MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i};
                exmem_alu_reg   <= alu_result;
                exmem_wdata_reg <= fwd_rt;
                exmem_rd_reg    <= dest;
            end
        end
    end

    assign MemRead_o   = exmem_ctrl_reg[3];
    assign MemWrite_o  = exmem_ctrl_reg[2];
    assign MemtoReg_o  = exmem_ctrl_reg[1];
    assign RegWrite_o  = exmem_ctrl_reg[0];
    assign ALUresult_o = exmem_alu_reg;
    assign MemWdata_o  = exmem_wdata_reg;
    assign RDaddr_o    = exmem_rd_reg;

endmodule
